// File: rtl/primus_pkg.sv
// Shared integer-pipeline types: load sizes, writeback entry layout, and
// architectural widths used across the pipeline.
package primus_pkg;

    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        LS_B = 2'b00,
        LS_H = 2'b01,
        LS_W = 2'b10,
        LS_D = 2'b11
    } ls_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_ONE   = 2'b01,
        BUF_TWO   = 2'b10
    } buf_state_e;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_load_fmt.sv
// Combinational load formatter: shifts the aligned doubleword down to the
// accessed bytes and sign- or zero-extends byte/half/word results.
module wb_load_fmt
    import primus_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [W-1:0] data_i,
    input  logic [2:0]   addr_lsb_i,
    input  ls_e          size_i,
    input  logic         unsigned_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] shifted;

    // Bytes moved past the top of the doubleword fill with zeros.
    assign shifted = data_i >> {addr_lsb_i, 3'b000};

    always_comb begin
        data_o = shifted;
        case (size_i)
            LS_B:    data_o = {{(W-8){~unsigned_i & shifted[7]}}, shifted[7:0]};
            LS_H:    data_o = {{(W-16){~unsigned_i & shifted[15]}}, shifted[15:0]};
            LS_W:    data_o = {{(W-32){~unsigned_i & shifted[31]}}, shifted[31:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: two-entry skid buffer feeding the register-file write port
// and the bypass network. Optional retire counter enabled by WB_INSTRET_EN.
//
// state     | meaning
// BUF_EMPTY | no buffered results, head invalid
// BUF_ONE   | one result at head, newest == oldest
// BUF_TWO   | two results, ready_o low until head drains
module wb_stage
    import primus_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_W     = REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  rd_we_i,
    input  logic [ADDR_W-1:0]     rd_addr_i,
    input  logic [DATA_WIDTH-1:0] result_i,
    input  logic                  is_load_i,
    input  logic [1:0]            load_size_i,
    input  logic                  load_unsigned_i,
    input  logic [2:0]            addr_lsb_i,
    input  logic [DATA_WIDTH-1:0] load_data_i,
    input  logic                  hold_i,
    output logic                  rf_we_o,
    output logic [ADDR_W-1:0]     rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  fwd0_valid_o,
    output logic [ADDR_W-1:0]     fwd0_addr_o,
    output logic [DATA_WIDTH-1:0] fwd0_data_o,
    output logic                  fwd1_valid_o,
    output logic [ADDR_W-1:0]     fwd1_addr_o,
    output logic [DATA_WIDTH-1:0] fwd1_data_o,
    output logic [63:0]           instret_o
);

    logic [DATA_WIDTH-1:0] load_fmt;
    logic [DATA_WIDTH-1:0] wdata_in;

    wb_load_fmt #(.W(DATA_WIDTH)) u_load_fmt (
        .data_i     (load_data_i),
        .addr_lsb_i (addr_lsb_i),
        .size_i     (ls_e'(load_size_i)),
        .unsigned_i (load_unsigned_i),
        .data_o     (load_fmt)
    );

    assign wdata_in = is_load_i ? load_fmt : result_i;

    buf_state_e                 state;
    buf_state_e                 state_nxt;
    logic                       rdy_q;
    logic                       head;
    logic                       tail;
    logic                       newest;
    logic [1:0]                 ent_we;
    logic [1:0][ADDR_W-1:0]     ent_addr;
    logic [1:0][DATA_WIDTH-1:0] ent_data;
    logic                       head_valid;
    logic                       push;
    logic                       pop;

    assign head_valid = (state != BUF_EMPTY);
    assign push       = valid_i & rdy_q;
    assign pop        = head_valid & ~hold_i;
    assign tail       = (state == BUF_EMPTY) ? head : ~head;
    assign newest     = (state == BUF_TWO) ? ~head : head;
    assign ready_o    = rdy_q;

    always_comb begin
        state_nxt = state;
        case (state)
            BUF_EMPTY: if (push) state_nxt = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_nxt = BUF_TWO;
                else if (pop && !push) state_nxt = BUF_EMPTY;
            end
            BUF_TWO:   if (pop) state_nxt = BUF_ONE;
            default:   state_nxt = BUF_EMPTY;
        endcase
    end

    // Entries are cleared on reset so the write-port outputs read as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= BUF_EMPTY;
            rdy_q    <= 1'b0;
            head     <= 1'b0;
            ent_we   <= '0;
            ent_addr <= '0;
            ent_data <= '0;
        end else begin
            state <= state_nxt;
            rdy_q <= (state_nxt != BUF_TWO);
            if (push) begin
                ent_we[tail]   <= rd_we_i;
                ent_addr[tail] <= rd_addr_i;
                ent_data[tail] <= wdata_in;
            end
            if (pop) head <= ~head;
        end
    end

    assign rf_we_o    = pop & ent_we[head] & (ent_addr[head] != '0);
    assign rf_waddr_o = ent_addr[head];
    assign rf_wdata_o = ent_data[head];

    assign fwd1_valid_o = head_valid & ent_we[head] & (ent_addr[head] != '0);
    assign fwd1_addr_o  = ent_addr[head];
    assign fwd1_data_o  = ent_data[head];

    assign fwd0_valid_o = head_valid & ent_we[newest] & (ent_addr[newest] != '0);
    assign fwd0_addr_o  = ent_addr[newest];
    assign fwd0_data_o  = ent_data[newest];

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)    instret_q <= '0;
        else if (pop) instret_q <= instret_q + 64'd1;
    end

    assign instret_o = instret_q;
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-format vector table, directed
// corner sequences, and randomized traffic against a queue-based model.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic        rd_we_i;
    logic [4:0]  rd_addr_i;
    logic [63:0] result_i;
    logic        is_load_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic [2:0]  addr_lsb_i;
    logic [63:0] load_data_i;
    logic        hold_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [63:0] rf_wdata_o;
    logic        fwd0_valid_o;
    logic [4:0]  fwd0_addr_o;
    logic [63:0] fwd0_data_o;
    logic        fwd1_valid_o;
    logic [4:0]  fwd1_addr_o;
    logic [63:0] fwd1_data_o;
    logic [63:0] instret_o;

    always #5 clk_i = ~clk_i;

    wb_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .rd_we_i         (rd_we_i),
        .rd_addr_i       (rd_addr_i),
        .result_i        (result_i),
        .is_load_i       (is_load_i),
        .load_size_i     (load_size_i),
        .load_unsigned_i (load_unsigned_i),
        .addr_lsb_i      (addr_lsb_i),
        .load_data_i     (load_data_i),
        .hold_i          (hold_i),
        .rf_we_o         (rf_we_o),
        .rf_waddr_o      (rf_waddr_o),
        .rf_wdata_o      (rf_wdata_o),
        .fwd0_valid_o    (fwd0_valid_o),
        .fwd0_addr_o     (fwd0_addr_o),
        .fwd0_data_o     (fwd0_data_o),
        .fwd1_valid_o    (fwd1_valid_o),
        .fwd1_addr_o     (fwd1_addr_o),
        .fwd1_data_o     (fwd1_data_o),
        .instret_o       (instret_o)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
    } m_entry_t;

    m_entry_t    m_q[$];
    logic [63:0] m_instret = '0;
    logic        m_rdy     = 1'b0;
    logic        m_known   = 1'b0;

    typedef struct {
        logic [63:0] ldata;
        logic [2:0]  lsb;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] exp;
    } fmt_vec_t;

    fmt_vec_t vecs[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] m_fmt(input logic [63:0] d, input logic [1:0] sz,
                                          input logic u, input logic [2:0] lsb);
        logic [63:0] v;
        logic [63:0] mask;
        int nb;
        v  = d >> (int'(lsb) * 8);
        nb = 8 << sz;
        if (nb == 64) return v;
        mask = (64'd1 << nb) - 64'd1;
        v = v & mask;
        if (!u && v[nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic m_fwd_ok(input m_entry_t e);
        return e.we && (e.addr != 5'd0);
    endfunction

    task automatic set_in(input logic v, input logic we, input logic [4:0] a, input logic [63:0] r,
                          input logic il, input logic [1:0] sz, input logic u, input logic [2:0] l,
                          input logic [63:0] ld, input logic h);
        valid_i = v; rd_we_i = we; rd_addr_i = a; result_i = r; is_load_i = il;
        load_size_i = sz; load_unsigned_i = u; addr_lsb_i = l; load_data_i = ld; hold_i = h;
    endtask

    task automatic check_all();
        logic exp_we;
        if (!m_known) return;
        chk("ready", {63'd0, ready_o}, {63'd0, m_rdy});
        exp_we = (m_q.size() > 0) && !hold_i && m_fwd_ok(m_q[0]);
        chk("rf_we", {63'd0, rf_we_o}, {63'd0, exp_we});
        if (m_q.size() > 0) begin
            chk("rf_waddr", {59'd0, rf_waddr_o}, {59'd0, m_q[0].addr});
            chk("rf_wdata", rf_wdata_o, m_q[0].data);
            chk("fwd1_valid", {63'd0, fwd1_valid_o}, {63'd0, m_fwd_ok(m_q[0])});
            chk("fwd0_valid", {63'd0, fwd0_valid_o}, {63'd0, m_fwd_ok(m_q[$])});
            if (m_fwd_ok(m_q[0])) chk("fwd1_data", fwd1_data_o, m_q[0].data);
            if (m_fwd_ok(m_q[$])) begin
                chk("fwd0_addr", {59'd0, fwd0_addr_o}, {59'd0, m_q[$].addr});
                chk("fwd0_data", fwd0_data_o, m_q[$].data);
            end
        end else begin
            chk("fwd1_valid_empty", {63'd0, fwd1_valid_o}, 64'd0);
            chk("fwd0_valid_empty", {63'd0, fwd0_valid_o}, 64'd0);
        end
`ifdef WB_INSTRET_EN
        chk("instret", instret_o, m_instret);
`else
        chk("instret_tied", instret_o, 64'd0);
`endif
    endtask

    task automatic model_edge();
        m_entry_t e;
        logic acc;
        logic pp;
        if (rst_i) begin
            m_q.delete();
            m_instret = '0;
            m_rdy     = 1'b0;
            m_known   = 1'b1;
            return;
        end
        if (!m_known) return;
        acc = valid_i && m_rdy;
        pp  = (m_q.size() > 0) && !hold_i;
        if (pp) begin
            void'(m_q.pop_front());
            m_instret = m_instret + 64'd1;
        end
        if (acc) begin
            e.we   = rd_we_i;
            e.addr = rd_addr_i;
            e.data = is_load_i ? m_fmt(load_data_i, load_size_i, load_unsigned_i, addr_lsb_i) : result_i;
            m_q.push_back(e);
        end
        m_rdy = (m_q.size() < 2);
    endtask

    task automatic step();
        #1 check_all();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
    endtask

    task automatic idle(input logic h);
        set_in(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, h);
    endtask

    initial begin
        logic [63:0] d;
        d = 64'h8877_6655_4433_2211;
        vecs[0]  = '{d, 3'd7, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF88};
        vecs[1]  = '{d, 3'd7, 2'd0, 1'b1, 64'h0000_0000_0000_0088};
        vecs[2]  = '{d, 3'd6, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8877};
        vecs[3]  = '{d, 3'd6, 2'd1, 1'b1, 64'h0000_0000_0000_8877};
        vecs[4]  = '{d, 3'd4, 2'd2, 1'b0, 64'hFFFF_FFFF_8877_6655};
        vecs[5]  = '{d, 3'd0, 2'd2, 1'b1, 64'h0000_0000_4433_2211};
        vecs[6]  = '{d, 3'd0, 2'd3, 1'b0, 64'h8877_6655_4433_2211};
        vecs[7]  = '{d, 3'd0, 2'd3, 1'b1, 64'h8877_6655_4433_2211};
        vecs[8]  = '{d, 3'd0, 2'd0, 1'b0, 64'h0000_0000_0000_0011};
        vecs[9]  = '{d, 3'd2, 2'd1, 1'b0, 64'h0000_0000_0000_4433};
        vecs[10] = '{64'h0000_0000_8000_0000, 3'd0, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000};
        vecs[11] = '{d, 3'd3, 2'd0, 1'b0, 64'h0000_0000_0000_0044};
        vecs[12] = '{d, 3'd7, 2'd1, 1'b0, 64'h0000_0000_0000_0088};
        vecs[13] = '{d, 3'd6, 2'd2, 1'b0, 64'h0000_0000_0000_8877};

        rst_i = 1'b1;
        idle(1'b0);
        @(negedge clk_i);
        step();
        #1 chk("ready_in_reset", {63'd0, ready_o}, 64'd0);
        rst_i = 1'b0;
        step();

        // First result after reset appears at the write port the next cycle.
        set_in(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b0);
        step();
        idle(1'b0);
        #1;
        chk("dbeef_we", {63'd0, rf_we_o}, 64'd1);
        chk("dbeef_waddr", {59'd0, rf_waddr_o}, 64'd5);
        chk("dbeef_wdata", rf_wdata_o, 64'h0000_0000_DEAD_BEEF);
        chk("dbeef_fwd1", {63'd0, fwd1_valid_o}, 64'd1);
        step();

        foreach (vecs[i]) begin
            set_in(1'b1, 1'b1, 5'(i + 1), 64'd0, 1'b1, vecs[i].size, vecs[i].uns,
                   vecs[i].lsb, vecs[i].ldata, 1'b0);
            step();
            idle(1'b0);
            #1;
            chk($sformatf("fmt_vec%0d", i), rf_wdata_o, vecs[i].exp);
            chk($sformatf("fmt_we%0d", i), {63'd0, rf_we_o}, 64'd1);
            step();
        end

        // x0 destination retires without writing.
        set_in(1'b1, 1'b1, 5'd0, 64'd1, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b0);
        step();
        idle(1'b0);
        #1;
        chk("x0_no_we", {63'd0, rf_we_o}, 64'd0);
        chk("x0_no_fwd", {63'd0, fwd1_valid_o}, 64'd0);
        step();

        // Hold with three back-to-back results.
        set_in(1'b1, 1'b1, 5'd1, 64'h11, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b1);
        step();
        set_in(1'b1, 1'b1, 5'd2, 64'h22, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b1);
        step();
        set_in(1'b1, 1'b1, 5'd3, 64'h33, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b1);
        #1 chk("hold_full_ready", {63'd0, ready_o}, 64'd0);
        chk("hold_no_we", {63'd0, rf_we_o}, 64'd0);
        step();
        hold_i = 1'b0;
        #1;
        chk("rel_we0", {63'd0, rf_we_o}, 64'd1);
        chk("rel_addr0", {59'd0, rf_waddr_o}, 64'd1);
        chk("rel_ready0", {63'd0, ready_o}, 64'd0);
        step();
        #1;
        chk("rel_addr1", {59'd0, rf_waddr_o}, 64'd2);
        chk("rel_ready1", {63'd0, ready_o}, 64'd1);
        step();
        idle(1'b0);
        #1 chk("rel_addr2", {59'd0, rf_waddr_o}, 64'd3);
        chk("rel_data2", rf_wdata_o, 64'h33);
        step();

        // Same destination twice: newest wins on fwd0.
        set_in(1'b1, 1'b1, 5'd7, 64'hA, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b1);
        step();
        set_in(1'b1, 1'b1, 5'd7, 64'hB, 1'b0, 2'd0, 1'b0, 3'd0, 64'd0, 1'b1);
        step();
        idle(1'b1);
        #1;
        chk("same_fwd0_data", fwd0_data_o, 64'hB);
        chk("same_fwd1_data", fwd1_data_o, 64'hA);
        chk("same_fwd0_valid", {63'd0, fwd0_valid_o}, 64'd1);
        chk("same_fwd1_valid", {63'd0, fwd1_valid_o}, 64'd1);
        step();

        // Reset with two entries buffered discards them.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        hold_i = 1'b0;
        #1;
        chk("rst_we", {63'd0, rf_we_o}, 64'd0);
        chk("rst_waddr", {59'd0, rf_waddr_o}, 64'd0);
        chk("rst_wdata", rf_wdata_o, 64'd0);
        chk("rst_fwd0", {63'd0, fwd0_valid_o}, 64'd0);
        chk("rst_fwd1", {63'd0, fwd1_valid_o}, 64'd0);
        chk("rst_instret", instret_o, 64'd0);
        step();
        #1 chk("rst_ready_after", {63'd0, ready_o}, 64'd1);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 99) < 70), 1'($urandom), 5'($urandom_range(0, 31)),
                   {$urandom, $urandom}, 1'($urandom), 2'($urandom), 1'($urandom),
                   3'($urandom), {$urandom, $urandom}, ($urandom_range(0, 99) < 30));
            rst_i = ($urandom_range(0, 199) == 0);
            step();
        end
        rst_i = 1'b0;
        idle(1'b0);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
